// File: rtl/cam_cfg_sequencer.sv
// Camera register-table sequencer: walks a ROM of {reg_addr, reg_value} words,
// drives each one through the I2C write engine with retry, and reports status.
module cam_cfg_sequencer #(
   parameter logic [7:0]  SLAVE_ADDR     = 8'h42,
   parameter logic [7:0]  TBL_LEN        = 8'd20,
   parameter logic [15:0] DELAY_MARKER   = 16'hFFF0,
   parameter logic [19:0] PWRUP_CYCLES   = 20'd500000,
   parameter logic [19:0] DELAY_CYCLES   = 20'd250000,
   parameter logic [19:0] TIMEOUT_CYCLES = 20'd100000,
   parameter logic [3:0]  MAX_RETRY      = 4'd3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [7:0]  tbl_index,
   input  logic [15:0] tbl_data,
   output logic [7:0]  sl_addr,
   output logic [7:0]  byte_num,
   output logic [15:0] reg_data,
   output logic        i2c_enable,
   input  logic        i2c_end,
   input  logic        i2c_ack,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [7:0]  err_index
);

   localparam int unsigned CNT_W   = 20;
   localparam int unsigned RETRY_W = 4;

   typedef enum logic [3:0] {
      S_PWRUP, S_LOAD, S_FETCH, S_DLY, S_GO, S_WAIT_BUSY,
      S_WAIT_END, S_CHECK, S_NEXT, S_DONE, S_FAIL
   } state_t;

   state_t               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [RETRY_W-1:0]   retry_q;
   logic                 timeout_q;
   logic [7:0]           idx_q;
   logic [15:0]          reg_q;
   logic                 en_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 error_q;
   logic [7:0]           err_idx_q;

   logic [RETRY_W-1:0]   retry_inc_c;
   logic                 attempt_bad_c;

   // Next retry value and pass/fail verdict of the attempt being checked
   always_comb begin
      retry_inc_c   = retry_q + RETRY_W'(1);
      attempt_bad_c = timeout_q | i2c_ack;
   end

   // Sequencer FSM with all outputs registered; counter restarts on every state entry
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_PWRUP;
         cnt_q     <= '0;
         retry_q   <= '0;
         timeout_q <= 1'b0;
         idx_q     <= '0;
         reg_q     <= '0;
         en_q      <= 1'b0;
         busy_q    <= 1'b1;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
         err_idx_q <= '0;
      end else begin
         case (state_q)
            S_PWRUP: begin
               if (cnt_q == PWRUP_CYCLES - CNT_W'(1)) begin
                  state_q <= S_LOAD;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_LOAD: begin
               state_q <= S_FETCH;
               cnt_q   <= '0;
            end
            S_FETCH: begin
               cnt_q <= '0;
               if (tbl_data == DELAY_MARKER) begin
                  state_q <= S_DLY;
               end else begin
                  reg_q     <= tbl_data;
                  state_q   <= S_GO;
                  en_q      <= 1'b1;
                  timeout_q <= 1'b0;
               end
            end
            S_DLY: begin
               if (cnt_q == DELAY_CYCLES - CNT_W'(1)) begin
                  state_q <= S_NEXT;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_GO: begin
               if (cnt_q == CNT_W'(1)) begin
                  en_q    <= 1'b0;
                  state_q <= S_WAIT_BUSY;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_WAIT_BUSY: begin
               if (!i2c_end) begin
                  state_q <= S_WAIT_END;
                  cnt_q   <= '0;
               end else if (cnt_q == TIMEOUT_CYCLES - CNT_W'(1)) begin
                  timeout_q <= 1'b1;
                  state_q   <= S_CHECK;
                  cnt_q     <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_WAIT_END: begin
               if (i2c_end) begin
                  state_q <= S_CHECK;
                  cnt_q   <= '0;
               end else if (cnt_q == TIMEOUT_CYCLES - CNT_W'(1)) begin
                  timeout_q <= 1'b1;
                  state_q   <= S_CHECK;
                  cnt_q     <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_CHECK: begin
               cnt_q <= '0;
               if (attempt_bad_c) begin
                  retry_q <= retry_inc_c;
                  if (retry_inc_c == MAX_RETRY) begin
                     state_q   <= S_FAIL;
                     busy_q    <= 1'b0;
                     error_q   <= 1'b1;
                     err_idx_q <= idx_q;
                  end else begin
                     state_q   <= S_GO;
                     en_q      <= 1'b1;
                     timeout_q <= 1'b0;
                  end
               end else begin
                  state_q <= S_NEXT;
               end
            end
            S_NEXT: begin
               cnt_q   <= '0;
               retry_q <= '0;
               if (idx_q == TBL_LEN - 8'd1) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  idx_q   <= idx_q + 8'd1;
                  state_q <= S_LOAD;
               end
            end
            S_DONE, S_FAIL: begin
               if (start) begin
                  idx_q   <= '0;
                  retry_q <= '0;
                  cnt_q   <= '0;
                  done_q  <= 1'b0;
                  error_q <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_LOAD;
               end
            end
            default: begin
               state_q <= S_PWRUP;
               cnt_q   <= '0;
               en_q    <= 1'b0;
            end
         endcase
      end
   end

   assign tbl_index  = idx_q;
   assign reg_data   = reg_q;
   assign i2c_enable = en_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign error      = error_q;
   assign err_index  = err_idx_q;
   assign sl_addr    = SLAVE_ADDR;
   assign byte_num   = 8'd2;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Directed bench for cam_cfg_sequencer with a small I2C engine model and table ROM.
module tb_cam_cfg_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  tbl_index;
   logic [15:0] tbl_data;
   logic [7:0]  sl_addr;
   logic [7:0]  byte_num;
   logic [15:0] reg_data;
   logic        i2c_enable;
   logic        i2c_end = 1'b1;
   logic        i2c_ack = 1'b0;
   logic        busy;
   logic        done;
   logic        error;
   logic [7:0]  err_index;

   logic [15:0] tbl [0:2];
   int          n_tests = 0;
   int          n_fail  = 0;

   // engine model controls (written by the stimulus)
   int          nack_xfer = -1;
   logic        nack_word_en = 1'b0;
   logic [15:0] nack_word = 16'h0000;
   logic        hang = 1'b0;

   // engine model state and transfer log
   int          cyc = 0;
   int          xfers = 0;
   int          eng_t = 0;
   logic        en_d = 1'b0;
   logic        nack_now = 1'b0;
   logic        seen_marker = 1'b0;
   logic [15:0] wlog [0:63];
   int          tcyc [0:63];
   int          ecyc [0:63];

   always #5 clk = ~clk;

   assign tbl_data = (tbl_index < 8'd3) ? tbl[tbl_index[1:0]] : 16'h0000;

   cam_cfg_sequencer #(
      .SLAVE_ADDR     (8'h42),
      .TBL_LEN        (8'd3),
      .DELAY_MARKER   (16'hFFF0),
      .PWRUP_CYCLES   (20'd4),
      .DELAY_CYCLES   (20'd8),
      .TIMEOUT_CYCLES (20'd50),
      .MAX_RETRY      (4'd3)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .tbl_index  (tbl_index),
      .tbl_data   (tbl_data),
      .sl_addr    (sl_addr),
      .byte_num   (byte_num),
      .reg_data   (reg_data),
      .i2c_enable (i2c_enable),
      .i2c_end    (i2c_end),
      .i2c_ack    (i2c_ack),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_index  (err_index)
   );

   // I2C engine model: logs each triggered word, drops end 1 cycle later, raises it 3 cycles after that
   always @(posedge clk) begin
      cyc  <= cyc + 1;
      en_d <= i2c_enable;
      if (reg_data == 16'hFFF0) seen_marker <= 1'b1;
      if (i2c_enable && !en_d) begin
         wlog[xfers] <= reg_data;
         tcyc[xfers] <= cyc;
         xfers       <= xfers + 1;
         nack_now    <= (nack_xfer == xfers) || (nack_word_en && reg_data == nack_word);
         eng_t       <= hang ? 0 : 1;
      end else if (eng_t != 0) begin
         eng_t <= eng_t + 1;
         if (eng_t == 1) i2c_end <= 1'b0;
         if (eng_t == 4) begin
            i2c_end         <= 1'b1;
            i2c_ack         <= nack_now;
            ecyc[xfers - 1] <= cyc;
            eng_t           <= 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_term(input string tag);
      int k;
      k = 0;
      while (!(done || error) && k < 3000) begin
         @(posedge clk);
         #1;
         k++;
      end
      chk(tag, 32'(done || error), 32'd1);
   endtask

   task automatic measure_en(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!i2c_enable && n < 200);
   endtask

   initial begin
      int n;
      int b;

      // reset state
      tbl[0] = 16'h1280; tbl[1] = 16'h1101; tbl[2] = 16'h0C04;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tbl_index", 32'(tbl_index), 32'h0);
      chk("rst_reg_data",  32'(reg_data),  32'h0);
      chk("rst_enable",    32'(i2c_enable), 32'h0);
      chk("rst_busy",      32'(busy),      32'h1);
      chk("rst_done",      32'(done),      32'h0);
      chk("rst_error",     32'(error),     32'h0);
      chk("rst_err_index", 32'(err_index), 32'h0);
      chk("sl_addr",       32'(sl_addr),   32'h42);
      chk("byte_num",      32'(byte_num),  32'h2);

      // happy path
      @(negedge clk);
      reset = 1'b1;
      measure_en(n);
      chk("first_enable_latency", 32'(n), 32'd6);
      wait_term("happy_term");
      chk("happy_xfers", 32'(xfers), 32'd3);
      chk("happy_w0", 32'(wlog[0]), 32'h1280);
      chk("happy_w1", 32'(wlog[1]), 32'h1101);
      chk("happy_w2", 32'(wlog[2]), 32'h0C04);
      chk("happy_done", 32'(done), 32'h1);
      chk("happy_busy", 32'(busy), 32'h0);
      chk("happy_error", 32'(error), 32'h0);
      chk("happy_tbl_index", 32'(tbl_index), 32'h2);

      // delay entry
      tbl[1] = 16'hFFF0;
      b = xfers;
      pulse_start();
      chk("restart_busy", 32'(busy), 32'h1);
      chk("restart_done", 32'(done), 32'h0);
      wait_term("dly_term");
      chk("dly_xfers", 32'(xfers - b), 32'd2);
      chk("dly_w0", 32'(wlog[b]), 32'h1280);
      chk("dly_w1", 32'(wlog[b + 1]), 32'h0C04);
      chk("dly_no_marker", 32'(seen_marker), 32'h0);
      chk("dly_gap_ge8", 32'((tcyc[b + 1] - ecyc[b]) >= 8), 32'd1);
      chk("dly_done", 32'(done), 32'h1);

      // single NACK on first attempt of entry 1
      tbl[1] = 16'h1101;
      b = xfers;
      nack_xfer = b + 1;
      pulse_start();
      wait_term("nack1_term");
      nack_xfer = -1;
      chk("nack1_xfers", 32'(xfers - b), 32'd4);
      chk("nack1_w1a", 32'(wlog[b + 1]), 32'h1101);
      chk("nack1_w1b", 32'(wlog[b + 2]), 32'h1101);
      chk("nack1_w2",  32'(wlog[b + 3]), 32'h0C04);
      chk("nack1_done", 32'(done), 32'h1);
      chk("nack1_error", 32'(error), 32'h0);

      // persistent NACK on entry 2
      b = xfers;
      nack_word = 16'h0C04;
      nack_word_en = 1'b1;
      pulse_start();
      wait_term("nackp_term");
      nack_word_en = 1'b0;
      chk("nackp_xfers", 32'(xfers - b), 32'd5);
      chk("nackp_w4", 32'(wlog[b + 4]), 32'h0C04);
      chk("nackp_error", 32'(error), 32'h1);
      chk("nackp_err_index", 32'(err_index), 32'h2);
      chk("nackp_done", 32'(done), 32'h0);
      chk("nackp_busy", 32'(busy), 32'h0);
      b = xfers;
      pulse_start();
      chk("rerun_error", 32'(error), 32'h0);
      chk("rerun_busy", 32'(busy), 32'h1);
      chk("rerun_tbl_index", 32'(tbl_index), 32'h0);
      wait_term("rerun_term");
      chk("rerun_xfers", 32'(xfers - b), 32'd3);
      chk("rerun_done", 32'(done), 32'h1);

      // timeout: engine never drops end
      hang = 1'b1;
      b = xfers;
      pulse_start();
      wait_term("to_term");
      hang = 1'b0;
      chk("to_attempts", 32'(xfers - b), 32'd3);
      chk("to_period_a", 32'(tcyc[b + 1] - tcyc[b]), 32'd53);
      chk("to_period_b", 32'(tcyc[b + 2] - tcyc[b + 1]), 32'd53);
      chk("to_error", 32'(error), 32'h1);
      chk("to_err_index", 32'(err_index), 32'h0);
      chk("to_done", 32'(done), 32'h0);

      // reset while enable is high on entry 2
      pulse_start();
      n = 0;
      while (!(i2c_enable && tbl_index == 8'd2) && n < 500) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("mid_enable_seen", 32'(i2c_enable && tbl_index == 8'd2), 32'd1);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_enable", 32'(i2c_enable), 32'h0);
      chk("mid_rst_tbl_index", 32'(tbl_index), 32'h0);
      chk("mid_rst_busy", 32'(busy), 32'h1);
      chk("mid_rst_reg_data", 32'(reg_data), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) start = 1'b1;
         if (n == 3) start = 1'b0;
      end while (!i2c_enable && n < 200);
      start = 1'b0;
      chk("mid_pwrup_latency", 32'(n), 32'd6);
      wait_term("mid_term");
      chk("mid_done", 32'(done), 32'h1);
      chk("mid_tbl_index", 32'(tbl_index), 32'h2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
